// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO bridge: I/O window base, register offsets,
// field widths and the switch debounce FSM state type.
package mmio_pkg;

  // address_dmem[11:8] equal to this nibble selects the I/O register bank
  localparam logic [3:0] IO_BASE = 4'hF;

  // Register offsets within the I/O window (address_dmem[7:0])
  localparam logic [7:0] OFF_SEG     = 8'h00;
  localparam logic [7:0] OFF_SEG_INC = 8'h01;
  localparam logic [7:0] OFF_LED     = 8'h02;
  localparam logic [7:0] OFF_SW      = 8'h03;
  localparam logic [7:0] OFF_DOT_X   = 8'h04;
  localparam logic [7:0] OFF_DOT_Y   = 8'h05;
  localparam logic [7:0] OFF_CYCLE   = 8'h06;
  localparam logic [7:0] OFF_SWFLAG  = 8'h07;

  localparam int DOT_X_W = 10;
  localparam int DOT_Y_W = 9;
  localparam int LED_W   = 16;
  localparam int SW_W    = 5;

  typedef enum logic {
    DEB_STABLE,
    DEB_SETTLING
  } deb_state_t;

endpackage

// File: rtl/sw_debounce.sv
// Switch conditioning: two-flop synchroniser followed by a debounce FSM that
// accepts a new 5-bit switch vector only after it has been seen unchanged for
// DEBOUNCE_CYCLES consecutive cycles. 'changed' is high in the cycle whose
// closing edge loads the new value into 'deb'.
module sw_debounce
  import mmio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [SW_W-1:0] sw_raw,
  output logic [SW_W-1:0] deb,
  output logic            changed
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0]  sync1, sync2;
  logic [SW_W-1:0]  cand, cand_nxt;
  logic [SW_W-1:0]  deb_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  deb_state_t       state, state_nxt;

  // Synchronise the asynchronous switches into the clock domain
  always_ff @(posedge clock) begin
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // Debounce FSM state, settle counter, candidate and accepted value
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= DEB_STABLE;
      cnt   <= '0;
      cand  <= '0;
      deb   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
      deb   <= deb_nxt;
    end
  end

  // Next-state logic: track the candidate value and count its stable cycles
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    deb_nxt   = deb;
    changed   = 1'b0;
    case (state)
      DEB_STABLE: begin
        if (sync2 != deb) begin
          state_nxt = DEB_SETTLING;
          cnt_nxt   = CNT_W'(1);
          cand_nxt  = sync2;
        end else begin
          cnt_nxt = '0;
        end
      end
      DEB_SETTLING: begin
        if (sync2 == deb) begin
          // Input bounced back to the accepted value: reject the change
          state_nxt = DEB_STABLE;
          cnt_nxt   = '0;
        end else if (sync2 != cand) begin
          // A different new value appeared mid-settle: start counting afresh
          cand_nxt = sync2;
          cnt_nxt  = CNT_W'(1);
        end else if (cnt >= CNT_LAST) begin
          deb_nxt   = sync2;
          state_nxt = DEB_STABLE;
          cnt_nxt   = '0;
          changed   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = DEB_STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/mmio_bridge.sv
// MMIO responder on the CPU dmem port. Addresses 0xF00-0xFFF hit the I/O
// register bank (7-seg value, LEDs, VGA dot, debounced switches, cycle
// counter); everything else passes through to RAM. Loads return one cycle
// after the address, matching the registered RAM.
// Optional feature macro MMIO_SW_IRQ_EN: sticky switch-change flag on sw_irq,
// readable (and cleared by reading) at offset 0x07.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int SEG_MAX         = 9999,
  parameter int SEG_RESET       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wren,
  input  logic [11:0]        address_dmem,
  input  logic [31:0]        data,
  output logic [31:0]        q_dmem,
  output logic               ram_wEn,
  input  logic [31:0]        ram_dataOut,
  input  logic [SW_W-1:0]    SW,
  output logic [LED_W-1:0]   led,
  output logic [31:0]        seg_value,
  output logic [DOT_X_W-1:0] dot_x,
  output logic [DOT_Y_W-1:0] dot_y,
  output logic               sw_irq
);

  localparam logic [31:0] SEG_MAX_V   = 32'(SEG_MAX);
  localparam logic [31:0] SEG_RESET_V = 32'(SEG_RESET);

  logic            io_hit;
  logic            io_wr;
  logic [7:0]      offset;
  logic [31:0]     cycle;
  logic [31:0]     io_rdata;
  logic            io_sel_q;
  logic [31:0]     io_rdata_q;
  logic [SW_W-1:0] sw_deb;
  logic            sw_changed;

  assign io_hit  = (address_dmem[11:8] == IO_BASE);
  assign offset  = address_dmem[7:0];
  assign io_wr   = wren & io_hit;
  assign ram_wEn = wren & ~io_hit;
  assign q_dmem  = io_sel_q ? io_rdata_q : ram_dataOut;

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clock  (clock),
    .reset  (reset),
    .sw_raw (SW),
    .deb    (sw_deb),
    .changed(sw_changed)
  );

  // Writable registers and the free-running cycle counter
  always_ff @(posedge clock) begin
    if (reset) begin
      seg_value <= SEG_RESET_V;
      led       <= '0;
      dot_x     <= '0;
      dot_y     <= '0;
      cycle     <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      if (io_wr) begin
        case (offset)
          OFF_SEG:     seg_value <= data;
          OFF_SEG_INC: seg_value <= (seg_value >= SEG_MAX_V) ? 32'd0 : seg_value + 32'd1;
          OFF_LED:     led       <= data[LED_W-1:0];
          OFF_DOT_X:   dot_x     <= data[DOT_X_W-1:0];
          OFF_DOT_Y:   dot_y     <= data[DOT_Y_W-1:0];
          OFF_CYCLE:   cycle     <= '0;  // clear overrides the increment above
          default:     ;                 // read-only or unmapped: ignored
        endcase
      end
    end
  end

`ifdef MMIO_SW_IRQ_EN
  logic sw_flag;
  logic swflag_rd;

  assign swflag_rd = io_hit & ~wren & (offset == OFF_SWFLAG);
  assign sw_irq    = sw_flag;

  // Sticky switch-change flag: a new debounced value sets it, a read clears it
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_flag <= 1'b0;
    end else if (sw_changed) begin
      sw_flag <= 1'b1;
    end else if (swflag_rd) begin
      sw_flag <= 1'b0;
    end
  end
`else
  // Change strobe has no consumer when the flag feature is absent
  logic sw_changed_unused;
  assign sw_changed_unused = sw_changed;
  assign sw_irq            = 1'b0;
`endif

  // Read mux over the register bank; narrow registers are zero-extended
  always_comb begin
    io_rdata = '0;
    case (offset)
      OFF_SEG:    io_rdata = seg_value;
      OFF_LED:    io_rdata = {{(32-LED_W){1'b0}}, led};
      OFF_SW:     io_rdata = {{(32-SW_W){1'b0}}, sw_deb};
      OFF_DOT_X:  io_rdata = {{(32-DOT_X_W){1'b0}}, dot_x};
      OFF_DOT_Y:  io_rdata = {{(32-DOT_Y_W){1'b0}}, dot_y};
      OFF_CYCLE:  io_rdata = cycle;
`ifdef MMIO_SW_IRQ_EN
      OFF_SWFLAG: io_rdata = {31'b0, sw_flag};
`endif
      default:    io_rdata = '0;
    endcase
  end

  // Register the I/O select and read data so loads line up with RAM latency
  always_ff @(posedge clock) begin
    if (reset) begin
      io_sel_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      io_sel_q   <= io_hit;
      io_rdata_q <= io_rdata;
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Scoreboard bench for mmio_bridge: the driver pushes expected values tagged
// with the cycle they become visible; a negedge monitor pops and compares.
module tb_mmio_bridge;

  localparam int DEB = 8;
`ifdef MMIO_SW_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        wren;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic [31:0] q_dmem;
  logic        ram_wEn;
  logic [31:0] ram_dataOut;
  logic [4:0]  SW;
  logic [15:0] led;
  logic [31:0] seg_value;
  logic [9:0]  dot_x;
  logic [8:0]  dot_y;
  logic        sw_irq;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef enum int {S_Q, S_WEN, S_SEG, S_LED, S_DOTX, S_DOTY, S_IRQ} sig_e;
  typedef struct {
    string       name;
    int          due;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  mmio_bridge #(
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock       (clk),
    .reset       (reset),
    .wren        (wren),
    .address_dmem(address_dmem),
    .data        (data),
    .q_dmem      (q_dmem),
    .ram_wEn     (ram_wEn),
    .ram_dataOut (ram_dataOut),
    .SW          (SW),
    .led         (led),
    .seg_value   (seg_value),
    .dot_x       (dot_x),
    .dot_y       (dot_y),
    .sw_irq      (sw_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered RAM behind the bridge, one-cycle read latency
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    ram_dataOut <= mem[address_dmem];
    if (ram_wEn) mem[address_dmem] <= data;
  end

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      S_Q:     return q_dmem;
      S_WEN:   return {31'b0, ram_wEn};
      S_SEG:   return seg_value;
      S_LED:   return {16'b0, led};
      S_DOTX:  return {22'b0, dot_x};
      S_DOTY:  return {23'b0, dot_y};
      S_IRQ:   return {31'b0, sw_irq};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic check(input string n, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s (cycle %0d)", n, cyc);
    end
  endtask

  // Monitor: compare every expectation that has come due this cycle
  always @(negedge clk) begin
    int i;
    logic [31:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        act = sample(sb[i].sig);
        checks++;
        if (act !== sb[i].exp) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                   sb[i].name, act, sb[i].exp, cyc);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic push(input string n, input sig_e s, input logic [31:0] e, input int lat);
    exp_t t;
    t.name = n;
    t.due  = cyc + lat;
    t.sig  = s;
    t.exp  = e;
    sb.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step();
    wren         = 1'b0;
    address_dmem = 12'h000;
  endtask

  task automatic store(input logic [11:0] a, input logic [31:0] d);
    step();
    wren         = 1'b1;
    address_dmem = a;
    data         = d;
  endtask

  task automatic load(input logic [11:0] a, input logic [31:0] e, input string n);
    step();
    wren         = 1'b0;
    address_dmem = a;
    push(n, S_Q, e, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    wren         = 1'b0;
    address_dmem = 12'h000;
    data         = 32'h0;
    SW           = 5'b0;
    ram_dataOut  = 32'h0;
    for (int k = 0; k < 4096; k++) mem[k] = 32'h0;

    // Reset state
    step();
    step();
    push("rst seg", S_SEG, 32'd0, 0);
    push("rst led", S_LED, 32'd0, 0);
    push("rst dotx", S_DOTX, 32'd0, 0);
    push("rst doty", S_DOTY, 32'd0, 0);
    push("rst irq", S_IRQ, 32'd0, 0);
    push("rst q", S_Q, 32'd0, 0);
    step();
    reset = 1'b0;

    // SEG read/write, I/O store never strobes RAM
    store(12'hF00, 32'h0000_1234);
    push("io store wen", S_WEN, 32'd0, 0);
    load(12'hF00, 32'h0000_1234, "seg rd");
    push("seg out", S_SEG, 32'h0000_1234, 0);

    // SEG_INC at and past the wrap limit
    store(12'hF00, 32'd9998);
    store(12'hF01, 32'hDEAD_BEEF);
    store(12'hF01, 32'h0);
    push("seg inc to max", S_SEG, 32'd9999, 0);
    load(12'hF00, 32'd0, "seg wrap rd");
    push("seg wrap", S_SEG, 32'd0, 0);

    // Narrow registers truncate on write, zero-extend on read
    store(12'hF02, 32'hFFFF_ABCD);
    load(12'hF02, 32'h0000_ABCD, "led rd");
    push("led out", S_LED, 32'h0000_ABCD, 0);
    store(12'hF04, 32'hFFFF_FFFF);
    store(12'hF05, 32'hFFFF_FFFF);
    load(12'hF04, 32'h0000_03FF, "dotx rd");
    push("dotx out", S_DOTX, 32'h0000_03FF, 0);
    load(12'hF05, 32'h0000_01FF, "doty rd");
    push("doty out", S_DOTY, 32'h0000_01FF, 0);

    // Unmapped and read-only offsets
    store(12'hF10, 32'h0000_0055);
    push("unmapped wen", S_WEN, 32'd0, 0);
    load(12'hF10, 32'd0, "unmapped rd");
    store(12'hF03, 32'h0000_001F);
    load(12'hF03, 32'd0, "sw ro rd");

    // RAM pass-through
    store(12'h010, 32'hCAFE_BABE);
    push("ram wen", S_WEN, 32'd1, 0);
    load(12'h010, 32'hCAFE_BABE, "ram rd");

    // CYCLE write-clear, then one elapsed cycle
    idle();
    idle();
    idle();
    store(12'hF06, 32'h1234_5678);
    load(12'hF06, 32'd0, "cycle clr rd");
    load(12'hF06, 32'd1, "cycle next rd");

    // Three-cycle glitch is rejected
    idle();
    SW = 5'b00101;
    idle();
    idle();
    idle();
    SW = 5'b00000;
    repeat (12) idle();
    load(12'hF03, 32'd0, "glitch rejected");

    // Held change is accepted exactly 2+DEB cycles later
    idle();
    SW = 5'b00101;
    repeat (DEB) idle();
    load(12'hF03, 32'd0, "sw before accept");
    push("irq before accept", S_IRQ, 32'd0, 0);
    load(12'hF03, 32'd5, "sw accepted");
    push("irq after accept", S_IRQ, {31'b0, IRQ_EN}, 0);
    load(12'hF07, {31'b0, IRQ_EN}, "swflag rd");
    load(12'hF07, 32'd0, "swflag cleared rd");
    push("irq cleared", S_IRQ, 32'd0, 0);

    // A different value mid-settle restarts the count
    idle();
    SW = 5'b00111;
    repeat (3) idle();
    idle();
    SW = 5'b00110;
    repeat (DEB) idle();
    load(12'hF03, 32'd5, "restart hold");
    load(12'hF03, 32'd6, "restart accept");

    // Reset mid-settle with registers loaded
    store(12'hF02, 32'h0000_FFFF);
    store(12'hF00, 32'd77);
    idle();
    SW = 5'b00000;
    repeat (4) idle();
    step();
    reset = 1'b1;
    step();
    push("mid rst seg", S_SEG, 32'd0, 0);
    push("mid rst led", S_LED, 32'd0, 0);
    push("mid rst dotx", S_DOTX, 32'd0, 0);
    push("mid rst doty", S_DOTY, 32'd0, 0);
    push("mid rst irq", S_IRQ, 32'd0, 0);
    reset = 1'b0;
    load(12'hF03, 32'd0, "sw after rst");

    // Debounce timing is exact again after reset
    idle();
    SW = 5'b00011;
    repeat (DEB) idle();
    load(12'hF03, 32'd0, "post rst before accept");
    load(12'hF03, 32'd3, "post rst accepted");

    idle();
    idle();
    idle();

    // Quiescent state after the final accepted change
    check("final seg", seg_value === 32'd0);
    check("final led", led === 16'h0000);
    check("final ram_wEn idle", ram_wEn === 1'b0);
    check("final irq", sw_irq === IRQ_EN);

    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: never compared, expected 0x%08h", sb[0].name, sb[0].exp);
      sb.delete(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
